// File: rtl/row_buffer_pkg.sv
// Shared defaults, derived widths and the FSM state type for the row buffer controller.
package row_buffer_pkg;

  localparam int K_DEF           = 3;
  localparam int STRIDE_DEF      = 1;
  localparam int ROW_LEN_DEF     = 64;
  localparam int FRAME_WORDS_DEF = 1792;

  // Width of a counter over 0..n-1, never narrower than one bit.
  function automatic int w_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROWS_DEF  = FRAME_WORDS_DEF / ROW_LEN_DEF;
  localparam int COL_W_DEF = w_of(ROW_LEN_DEF);
  localparam int ROW_W_DEF = w_of(ROWS_DEF);
  localparam int BANK_W_DEF = w_of(K_DEF);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    STREAM,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/row_buffer_ctrl_if.sv
// Upstream beat, line-buffer write and PE window handshake bundle for row_buffer_ctrl.
interface row_buffer_ctrl_if #(
  parameter int K           = row_buffer_pkg::K_DEF,
  parameter int ROW_LEN     = row_buffer_pkg::ROW_LEN_DEF,
  parameter int FRAME_WORDS = row_buffer_pkg::FRAME_WORDS_DEF
);
  localparam int CW = row_buffer_pkg::w_of(ROW_LEN);
  localparam int RW = row_buffer_pkg::w_of(FRAME_WORDS / ROW_LEN);
  localparam int BW = row_buffer_pkg::w_of(K);

  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          lb_wr_en;
  logic [CW-1:0] lb_addr;
  logic [BW-1:0] lb_bank;
  logic          win_valid;
  logic          pe_ready;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          frame_done;
  logic          busy;

  // master: upstream/PE side; slave: the controller
  modport master (
    output start, in_valid, pe_ready,
    input  in_ready, lb_wr_en, lb_addr, lb_bank, win_valid, win_row, win_col,
           frame_done, busy
  );

  modport slave (
    input  start, in_valid, pe_ready,
    output in_ready, lb_wr_en, lb_addr, lb_bank, win_valid, win_row, win_col,
           frame_done, busy
  );

endinterface

// File: rtl/rb_pos_counter.sv
// Column/row/bank position tracker with stride phases for the row buffer controller.
module rb_pos_counter
  import row_buffer_pkg::*;
#(
  parameter int K       = K_DEF,
  parameter int STRIDE  = STRIDE_DEF,
  parameter int ROW_LEN = ROW_LEN_DEF,
  parameter int ROWS    = ROWS_DEF,
  localparam int CW = w_of(ROW_LEN),
  localparam int RW = w_of(ROWS),
  localparam int BW = w_of(K),
  localparam int SW = w_of(STRIDE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic [BW-1:0] bank,
  output logic [SW-1:0] col_ph,
  output logic [SW-1:0] row_ph,
  output logic          col_last,
  output logic          row_last
);

  assign col_last = (col == CW'(ROW_LEN - 1));
  assign row_last = (row == RW'(ROWS - 1));

  // col_ph/row_ph track col%STRIDE and row%STRIDE without a divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      bank   <= '0;
      col_ph <= '0;
      row_ph <= '0;
    end else if (clr) begin
      col    <= '0;
      row    <= '0;
      bank   <= '0;
      col_ph <= '0;
      row_ph <= '0;
    end else if (adv) begin
      if (col_last) begin
        col    <= '0;
        col_ph <= '0;
        row    <= row_last ? '0 : row + 1'b1;
        row_ph <= (row_last || row_ph == SW'(STRIDE - 1)) ? '0 : row_ph + 1'b1;
        bank   <= (bank == BW'(K - 1)) ? '0 : bank + 1'b1;
      end else begin
        col    <= col + 1'b1;
        col_ph <= (col_ph == SW'(STRIDE - 1)) ? '0 : col_ph + 1'b1;
      end
    end
  end

endmodule

// File: rtl/row_buffer_ctrl.sv
// Line-buffer write sequencing and KxK window issue for a streaming convolution front end.
// Optional feature: define ROWBUF_CTRL_PERF_EN to add the perf_stall_cnt output.
module row_buffer_ctrl
  import row_buffer_pkg::*;
#(
  parameter int K           = K_DEF,
  parameter int STRIDE      = STRIDE_DEF,
  parameter int ROW_LEN     = ROW_LEN_DEF,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  row_buffer_ctrl_if.slave      bus
`ifdef ROWBUF_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam int ROWS = FRAME_WORDS / ROW_LEN;
  localparam int CW   = w_of(ROW_LEN);
  localparam int RW   = w_of(ROWS);
  localparam int BW   = w_of(K);
  localparam int SW   = w_of(STRIDE);
  localparam int PH0  = (K - 1) % STRIDE;

  state_t        state, nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [BW-1:0] bank;
  logic [SW-1:0] col_ph, row_ph;
  logic          col_last, row_last;
  logic          clr, in_run, in_ready, accept, win_hit;
  logic          win_valid;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;

  rb_pos_counter #(
    .K(K), .STRIDE(STRIDE), .ROW_LEN(ROW_LEN), .ROWS(ROWS)
  ) u_pos (
    .clk(clk), .rst(rst), .clr(clr), .adv(accept),
    .col(col), .row(row), .bank(bank),
    .col_ph(col_ph), .row_ph(row_ph),
    .col_last(col_last), .row_last(row_last)
  );

  // A pending window blocks input so it can never be overwritten
  assign in_run   = (state == FILL) || (state == STREAM);
  assign in_ready = in_run && !(win_valid && !bus.pe_ready);
  assign accept   = bus.in_valid && in_ready;

  // Rows >= K-1 are implied by STREAM
  assign win_hit = (state == STREAM) && accept && (col >= CW'(K - 1)) &&
                   (col_ph == SW'(PH0)) && (row_ph == SW'(PH0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    clr = 1'b0;
    case (state)
      IDLE:   if (bus.start) begin
                nxt = FILL;
                clr = 1'b1;
              end
      FILL:   if (accept && row == RW'(K - 2) && col_last) nxt = STREAM;
      STREAM: if (accept && row_last && col_last) nxt = FLUSH;
      FLUSH:  if (!win_valid || bus.pe_ready) nxt = DONE;
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // A new qualifying beat in the transfer cycle replaces the outgoing window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else if (win_hit) begin
      win_valid <= 1'b1;
      win_row   <= row;
      win_col   <= col;
    end else if (win_valid && bus.pe_ready) begin
      win_valid <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.lb_wr_en   = accept;
  assign bus.lb_addr    = col;
  assign bus.lb_bank    = bank;
  assign bus.win_valid  = win_valid;
  assign bus.win_row    = win_row;
  assign bus.win_col    = win_col;
  assign bus.frame_done = (state == DONE);
  assign bus.busy       = (state != IDLE);

`ifdef ROWBUF_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_stall_cnt <= '0;
    else if (state == IDLE && bus.start)
      perf_stall_cnt <= '0;
    else if (in_run && bus.in_valid && !in_ready && perf_stall_cnt != '1)
      perf_stall_cnt <= perf_stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_row_buffer_ctrl.sv
// Directed bench for row_buffer_ctrl: stride-1 and stride-2 instances, stall, reset and ignore cases.
module tb_row_buffer_ctrl;

  localparam int FW = 1792;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  row_buffer_ctrl_if #(.K(3), .ROW_LEN(64), .FRAME_WORDS(FW)) bus1();
  row_buffer_ctrl_if #(.K(3), .ROW_LEN(64), .FRAME_WORDS(FW)) bus2();

`ifdef ROWBUF_CTRL_PERF_EN
  logic [31:0] perf1, perf2;
`endif

  row_buffer_ctrl #(.K(3), .STRIDE(1), .ROW_LEN(64), .FRAME_WORDS(FW)) u_dut (
    .clk(clk), .rst(rst), .bus(bus1)
`ifdef ROWBUF_CTRL_PERF_EN
    , .perf_stall_cnt(perf1)
`endif
  );

  row_buffer_ctrl #(.K(3), .STRIDE(2), .ROW_LEN(64), .FRAME_WORDS(FW)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
`ifdef ROWBUF_CTRL_PERF_EN
    , .perf_stall_cnt(perf2)
`endif
  );

  int n_pass = 0, n_total = 0;
  int s_beats, s_win, s_done, s_first_beat, s_first_r, s_first_c;
  int s_addr_err, s_sb_err, s_wr_err, s_stall_viol, s_hold_err, s_stall_cyc, s_idle_err, s_timeout;
  int exp_q[$];
  int col_seq[$];

  // Snapshot of the selected instance's outputs
  logic o_ready, o_wr, o_wv, o_fd, o_busy;
  int   o_addr, o_bank, o_wrow, o_wcol;

  task automatic drive(input bit sel, input bit st, input bit iv, input bit pr);
    if (sel) begin bus2.start = st; bus2.in_valid = iv; bus2.pe_ready = pr; end
    else     begin bus1.start = st; bus1.in_valid = iv; bus1.pe_ready = pr; end
  endtask

  task automatic snap(input bit sel);
    if (sel) begin
      o_ready = bus2.in_ready; o_wr = bus2.lb_wr_en; o_wv = bus2.win_valid; o_fd = bus2.frame_done;
      o_busy = bus2.busy; o_addr = int'(bus2.lb_addr); o_bank = int'(bus2.lb_bank);
      o_wrow = int'(bus2.win_row); o_wcol = int'(bus2.win_col);
    end else begin
      o_ready = bus1.in_ready; o_wr = bus1.lb_wr_en; o_wv = bus1.win_valid; o_fd = bus1.frame_done;
      o_busy = bus1.busy; o_addr = int'(bus1.lb_addr); o_bank = int'(bus1.lb_bank);
      o_wrow = int'(bus1.win_row); o_wcol = int'(bus1.win_col);
    end
  endtask

  // Runs one frame (or max_beats of it) and gathers statistics against a scoreboard model.
  task automatic run_frame(input bit sel, input int stride, input int stall_n,
                           input int max_beats, input bit poke);
    int  m_col = 0, m_row = 0, stall_left = stall_n, post = 0;
    bit  fin = 0, iv, pr, st;
    s_beats = 0; s_win = 0; s_done = 0; s_first_beat = -1; s_first_r = -1; s_first_c = -1;
    s_addr_err = 0; s_sb_err = 0; s_wr_err = 0; s_stall_viol = 0; s_hold_err = 0;
    s_stall_cyc = 0; s_idle_err = 0; s_timeout = 0;
    exp_q.delete(); col_seq.delete();
    if (poke) repeat (3) begin
      @(negedge clk); drive(sel, 1'b0, 1'b1, 1'b1); #1; snap(sel);
      if (o_ready !== 1'b0 || o_wr !== 1'b0 || o_busy !== 1'b0) s_idle_err++;
    end
    @(negedge clk); drive(sel, 1'b1, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      iv = (s_beats < max_beats);
      pr = !(stall_left > 0 && (sel ? bus2.win_valid : bus1.win_valid));
      if (!pr) stall_left--;
      st = poke && (s_beats == 700);
      drive(sel, st, iv, pr);
      #1; snap(sel);
      if (o_wr !== (iv && o_ready)) s_wr_err++;
      if (o_wv && s_first_beat < 0) begin
        s_first_beat = s_beats - 1; s_first_r = o_wrow; s_first_c = o_wcol;
      end
      if (o_wv && !pr) begin
        s_stall_cyc++;
        if (o_ready !== 1'b0) s_stall_viol++;
        if (o_wrow != 2 || o_wcol != 2) s_hold_err++;
      end
      if (o_wv && pr) begin
        s_win++;
        if (exp_q.size() == 0) s_sb_err++;
        else if (exp_q.pop_front() != o_wrow * 1024 + o_wcol) s_sb_err++;
        if (o_wrow == 2) col_seq.push_back(o_wcol);
      end
      if (o_wr) begin
        if (o_addr != m_col || o_bank != m_row % 3) s_addr_err++;
        if (m_row >= 2 && m_col >= 2 && (m_row - 2) % stride == 0 && (m_col - 2) % stride == 0)
          exp_q.push_back(m_row * 1024 + m_col);
        s_beats++;
        m_col++;
        if (m_col == 64) begin m_col = 0; m_row++; end
      end
      if (o_fd) s_done++;
      if (s_done > 0) post++;
      if (post == 4) fin = 1;
      if (max_beats < FW && s_beats == max_beats) fin = 1;
    end
    if (!fin) s_timeout = 1;
    if (exp_q.size() != 0 && max_beats == FW) s_sb_err++;
    @(negedge clk); drive(sel, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    #1; snap(1'b0);
    n_total++; if ({o_ready, o_wr, o_wv, o_fd, o_busy} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {o_ready, o_wr, o_wv, o_fd, o_busy}); else n_pass++;
    n_total++; if (o_addr + o_bank + o_wrow + o_wcol != 0) $display("FAIL reset_coords: got addr=%0d bank=%0d row=%0d col=%0d expected all 0", o_addr, o_bank, o_wrow, o_wcol); else n_pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_full_frame;
    run_frame(1'b0, 1, 0, FW, 1'b0);
    n_total++; if (s_timeout != 0) $display("FAIL full_timeout: frame_done not seen within budget"); else n_pass++;
    n_total++; if (s_win != 1612) $display("FAIL full_windows: got %0d expected 1612", s_win); else n_pass++;
    n_total++; if (s_done != 1) $display("FAIL full_frame_done: got %0d expected 1", s_done); else n_pass++;
    n_total++; if (s_beats != FW) $display("FAIL full_beats: got %0d expected %0d", s_beats, FW); else n_pass++;
    n_total++; if (s_first_beat != 130) $display("FAIL first_win_latency: got beat %0d expected 130", s_first_beat); else n_pass++;
    n_total++; if (s_first_r != 2 || s_first_c != 2) $display("FAIL first_win_coord: got %0d/%0d expected 2/2", s_first_r, s_first_c); else n_pass++;
    n_total++; if (s_addr_err != 0) $display("FAIL addr_bank_trace: got %0d errors expected 0", s_addr_err); else n_pass++;
    n_total++; if (s_sb_err != 0) $display("FAIL window_scoreboard: got %0d errors expected 0", s_sb_err); else n_pass++;
    n_total++; if (s_wr_err != 0) $display("FAIL wr_en_handshake: got %0d errors expected 0", s_wr_err); else n_pass++;
    snap(1'b0);
    n_total++; if (o_busy !== 1'b0) $display("FAIL idle_after_frame: busy got %b expected 0", o_busy); else n_pass++;
  endtask

  task automatic test_stall;
    run_frame(1'b0, 1, 5, FW, 1'b0);
    n_total++; if (s_stall_cyc != 5) $display("FAIL stall_cycles: got %0d expected 5", s_stall_cyc); else n_pass++;
    n_total++; if (s_stall_viol != 0) $display("FAIL stall_in_ready: got %0d cycles with in_ready=1 expected 0", s_stall_viol); else n_pass++;
    n_total++; if (s_hold_err != 0) $display("FAIL stall_hold_coord: got %0d errors expected 0", s_hold_err); else n_pass++;
    n_total++; if (s_win != 1612 || s_sb_err != 0) $display("FAIL stall_windows: got %0d (sb err %0d) expected 1612 (0)", s_win, s_sb_err); else n_pass++;
    n_total++; if (s_beats != FW) $display("FAIL stall_beats: got %0d expected %0d", s_beats, FW); else n_pass++;
`ifdef ROWBUF_CTRL_PERF_EN
    n_total++; if (perf1 !== 32'd5) $display("FAIL perf_stall_cnt: got %0d expected 5", perf1); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid;
    int leak = 0;
    run_frame(1'b0, 1, 0, 500, 1'b0);
    @(negedge clk); bus1.in_valid = 1'b0; rst = 1'b1;
    #1; snap(1'b0);
    n_total++; if ({o_ready, o_wr, o_wv, o_fd, o_busy} !== 5'b0) $display("FAIL midrst_flags: got %b expected 00000", {o_ready, o_wr, o_wv, o_fd, o_busy}); else n_pass++;
    n_total++; if (o_addr + o_bank + o_wrow + o_wcol != 0) $display("FAIL midrst_coords: got addr=%0d bank=%0d row=%0d col=%0d expected all 0", o_addr, o_bank, o_wrow, o_wcol); else n_pass++;
    @(negedge clk); rst = 1'b0;
    repeat (5) begin
      @(negedge clk); bus1.in_valid = 1'b1; #1; snap(1'b0);
      if (o_ready !== 1'b0 || o_busy !== 1'b0 || o_wr !== 1'b0) leak++;
    end
    n_total++; if (leak != 0) $display("FAIL no_start_after_rst: got %0d active cycles expected 0", leak); else n_pass++;
    bus1.in_valid = 1'b0;
    run_frame(1'b0, 1, 0, FW, 1'b0);
    n_total++; if (s_win != 1612 || s_done != 1 || s_sb_err != 0) $display("FAIL midrst_refill: got win=%0d done=%0d sb=%0d expected 1612/1/0", s_win, s_done, s_sb_err); else n_pass++;
  endtask

  task automatic test_ignore;
    run_frame(1'b0, 1, 0, FW, 1'b1);
    n_total++; if (s_idle_err != 0) $display("FAIL idle_in_valid: got %0d reacting cycles expected 0", s_idle_err); else n_pass++;
    n_total++; if (s_win != 1612 || s_done != 1) $display("FAIL start_in_stream: got win=%0d done=%0d expected 1612/1", s_win, s_done); else n_pass++;
    n_total++; if (s_addr_err != 0 || s_sb_err != 0 || s_beats != FW) $display("FAIL start_in_stream_trace: got addr err %0d sb err %0d beats %0d expected 0/0/%0d", s_addr_err, s_sb_err, s_beats, FW); else n_pass++;
  endtask

  task automatic test_stride2;
    int seq_err = 0;
    run_frame(1'b1, 2, 0, FW, 1'b0);
    n_total++; if (s_win != 403 || s_done != 1) $display("FAIL stride2_windows: got win=%0d done=%0d expected 403/1", s_win, s_done); else n_pass++;
    n_total++; if (s_sb_err != 0) $display("FAIL stride2_scoreboard: got %0d errors expected 0", s_sb_err); else n_pass++;
    if (col_seq.size() != 31) seq_err++;
    foreach (col_seq[i]) if (col_seq[i] != 2 + 2 * i) seq_err++;
    n_total++; if (seq_err != 0) $display("FAIL stride2_col_seq: got %0d entries (%0d bad) expected 2,4,..,62", col_seq.size(), seq_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_reset_mid();
    test_ignore();
    test_stride2();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
